// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the yIF/yID/yEX/yDM/yWB/yPC
// datapath.
//
// Signals
//   opCode, funct3  instruction fields from the instruction register
//   zero            ALU zero flag (meaningful in EXEC)
//   mem_ready       memory handshake
//   ir_we, pc_we    instruction-register latch / PC update strobes
//   pc_sel          PC source: 00 PC+4, 01 branchImm, 10 jImm, 11 entryPoint
//   RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op   datapath controls
//
// Handshake: a memory access (instruction fetch in FETCH, MemRead/MemWrite in
// MEM) is requested for as long as the controller sits in that state, and it
// completes in the first cycle where mem_ready is high. The request stays
// asserted and unchanged until then. There is no separate valid strobe for
// fetch: being in FETCH is the request.
//
// Modports: master = controller, slave = datapath.
interface multicycle_ctrl_if;
    logic [6:0] opCode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       RegWrite;
    logic       ALUSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       Mem2Reg;
    logic [2:0] op;

    modport master (
        input  opCode, funct3, zero, mem_ready,
        output ir_we, pc_we, pc_sel, RegWrite, ALUSrc, MemRead, MemWrite,
               Mem2Reg, op
    );

    modport slave (
        output opCode, funct3, zero, mem_ready,
        input  ir_we, pc_we, pc_sel, RegWrite, ALUSrc, MemRead, MemWrite,
               Mem2Reg, op
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the core datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on mem_ready for memory accesses, traps
// illegal instructions and memory timeouts back to the entry point, counts
// retired instructions and halts after MAX_INSN of them (0 = run forever).
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         control bus (master side), see multicycle_ctrl_if
//   state       current FSM state (ENTRY=0 .. HALT=7)
//   insn_count  retired instruction counter
//   halted      high while in HALT
//   trap        one-cycle pulse in TRAP
module multicycle_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MAX_INSN    = 43,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    insn_count,
    output logic                halted,
    output logic                trap
);

    typedef enum logic [2:0] {
        ST_ENTRY  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R  = 3'd0,
        C_I  = 3'd1,
        C_LW = 3'd2,
        C_S  = 3'd3,
        C_B  = 3'd4,
        C_J  = 3'd5
    } cls_t;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;

    // The wait counter only needs to count 0 .. MEM_TIMEOUT-1; the cycle in
    // which it would reach MEM_TIMEOUT is the one that takes the trap.
    localparam int             WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INSN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            st_q, st_d;
    cls_t              cls_q;
    logic [2:0]        op_q;
    logic              asrc_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;

    // Decode of the current instruction-register fields.
    cls_t       dec_cls;
    logic       dec_ok;
    logic [2:0] dec_op;
    logic       dec_asrc;

    // Control produced by the next-state process.
    logic       retire;
    logic       load_dec;
    logic       wait_inc;
    logic [CNT_W-1:0] cnt_inc;

    logic       ir_we_c, pc_we_c, regwrite_c, alusrc_c, memread_c, memwrite_c, mem2reg_c;
    logic [1:0] pc_sel_c;
    logic [2:0] op_c;
    logic       trap_c, halted_c;

    // R/I funct3 to ALU op; only the four supported functions are legal.
    always_comb begin
        dec_cls  = C_R;
        dec_ok   = 1'b0;
        dec_op   = OP_ADD;
        dec_asrc = 1'b0;
        case (bus.opCode)
            7'b0110011, 7'b0010011: begin
                dec_cls  = (bus.opCode == 7'b0110011) ? C_R : C_I;
                dec_asrc = (bus.opCode == 7'b0010011);
                dec_ok   = 1'b1;
                case (bus.funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_ok = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec_cls  = C_LW;
                dec_asrc = 1'b1;
                dec_ok   = 1'b1;
            end
            7'b0100011: begin
                dec_cls  = C_S;
                dec_asrc = 1'b1;
                dec_ok   = 1'b1;
            end
            7'b1100011: begin
                dec_cls = C_B;
                dec_op  = OP_SUB;
                dec_ok  = (bus.funct3 == 3'b000);
            end
            7'b1101111: begin
                dec_cls = C_J;
                dec_ok  = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    // Next state and outputs.
    always_comb begin
        st_d       = st_q;
        retire     = 1'b0;
        load_dec   = 1'b0;
        wait_inc   = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 2'b00;
        regwrite_c = 1'b0;
        alusrc_c   = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        mem2reg_c  = 1'b0;
        op_c       = OP_ADD;
        trap_c     = 1'b0;
        halted_c   = 1'b0;

        case (st_q)
            ST_ENTRY: begin
                pc_we_c  = 1'b1;
                pc_sel_c = 2'b11;
                st_d     = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_we_c = 1'b1;
                    st_d    = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    st_d = ST_TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_ok) begin
                    load_dec = 1'b1;
                    st_d     = ST_EXEC;
                end else begin
                    st_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                op_c     = op_q;
                alusrc_c = asrc_q;
                case (cls_q)
                    C_B: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = bus.zero ? 2'b01 : 2'b00;
                        retire   = 1'b1;
                    end
                    C_LW, C_S: st_d = ST_MEM;
                    default:   st_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                op_c       = op_q;
                alusrc_c   = asrc_q;
                memread_c  = (cls_q == C_LW);
                memwrite_c = (cls_q == C_S);
                if (bus.mem_ready) begin
                    if (cls_q == C_LW) begin
                        st_d = ST_WB;
                    end else begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    st_d = ST_TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                op_c       = op_q;
                alusrc_c   = asrc_q;
                regwrite_c = 1'b1;
                mem2reg_c  = (cls_q == C_LW);
                pc_we_c    = 1'b1;
                pc_sel_c   = (cls_q == C_J) ? 2'b10 : 2'b00;
                retire     = 1'b1;
            end
            ST_TRAP: begin
                trap_c   = 1'b1;
                pc_we_c  = 1'b1;
                pc_sel_c = 2'b11;
                st_d     = ST_FETCH;
            end
            ST_HALT: begin
                halted_c = 1'b1;
            end
            default: st_d = ST_ENTRY;
        endcase

        // Every retiring state returns to FETCH unless this retirement
        // reaches the configured limit.
        if (retire) begin
            if ((MAX_INSN != 0) && (cnt_inc == MAX_CNT)) begin
                st_d = ST_HALT;
            end else begin
                st_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_ENTRY;
            cls_q  <= C_R;
            op_q   <= OP_ADD;
            asrc_q <= 1'b0;
            wait_q <= '0;
            cnt_q  <= '0;
        end else begin
            st_q <= st_d;
            if (load_dec) begin
                cls_q  <= dec_cls;
                op_q   <= dec_op;
                asrc_q <= dec_asrc;
            end
            // Any state change clears the wait counter, which covers entry
            // to both FETCH and MEM.
            if (st_d != st_q) begin
                wait_q <= '0;
            end else if (wait_inc) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (retire) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign bus.ir_we    = ir_we_c;
    assign bus.pc_we    = pc_we_c;
    assign bus.pc_sel   = pc_sel_c;
    assign bus.RegWrite = regwrite_c;
    assign bus.ALUSrc   = alusrc_c;
    assign bus.MemRead  = memread_c;
    assign bus.MemWrite = memwrite_c;
    assign bus.Mem2Reg  = mem2reg_c;
    assign bus.op       = op_c;

    assign state      = st_q;
    assign insn_count = cnt_q;
    assign halted     = halted_c;
    assign trap       = trap_c;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised multi-cycle sequencer that replaces the one-instruction-per-bench-loop control of the single-cycle core.
- Steps fetch/decode/execute/memory/writeback as explicit FSM states and waits on a memory-ready handshake.
- Traps illegal opcodes and memory timeouts to the entry point.
- Counts retired instructions and halts after a configurable number.
- Drives the existing yIF/yID/yEX/yDM/yWB/yPC datapath in place of yC1..yC4.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- MAX_INSN, 43: halt after this many retirements; 0 means never halt.
- MEM_TIMEOUT, 8: maximum cycles spent waiting on mem_ready in FETCH or MEM before a trap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opCode  in  7  ins[6:0], stable from the cycle after ir_we.
- funct3  in  3  ins[14:12].
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory handshake; the access completes in any cycle where it is high.
- ir_we  out  1  latch the instruction register.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  00 PC+4, 01 branchImm, 10 jImm, 11 entryPoint.
- RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1 each  datapath controls.
- op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  3  current FSM state (encoding below).
- insn_count  out  CNT_W  number of retired instructions.
- halted  out  1  sticky halt flag.
- trap  out  1  one-cycle pulse in the TRAP state.

Behaviour:
- All registers reset synchronously on rst=1, which has priority over every other event including mid-access and HALT.
- Next state after rst is ENTRY; insn_count=0; halted=0.
- All outputs are 0 in any state or cycle not listed below, except op=010.
- State encoding: ENTRY=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, HALT=7.
- ENTRY (1 cycle): pc_we=1, pc_sel=11 -> FETCH.
- FETCH: waits for mem_ready.
  - On mem_ready=1: ir_we=1 -> DECODE.
  - Otherwise the wait counter increments; when it reaches MEM_TIMEOUT -> TRAP.
  - The wait counter clears on entry to FETCH and to MEM.
- DECODE (1 cycle): registers the instruction class from opCode/funct3.
  - Classes: R=0110011, I=0010011, LW=0000011, S=0100011, B=1100011, J=1101111.
  - Any other opcode -> TRAP.
  - R/I funct3 not in {000,010,110,111} -> TRAP.
  - B with funct3 != 000 -> TRAP.
- ALU op mapping, held from EXEC to the end of the instruction:
  - R/I: funct3 000->010, 111->000, 110->001, 010->111.
  - LW/S/J: 010.
  - B: 110.
- ALUSrc=1 for I, LW, S, held EXEC through end of the instruction.
- EXEC (1 cycle):
  - B: pc_we=1, pc_sel=(zero?01:00), retire -> FETCH.
  - LW/S -> MEM.
  - R/I/J -> WB.
- MEM:
  - LW asserts MemRead; S asserts MemWrite; both held until mem_ready=1.
  - LW on ready -> WB.
  - S on ready: pc_we=1, pc_sel=00, retire -> FETCH.
  - Timeout as in FETCH -> TRAP; MemWrite deasserts in the TRAP cycle.
- WB (1 cycle): RegWrite=1, Mem2Reg=1 for LW, pc_we=1, pc_sel=10 for J else 00, retire -> FETCH.
- Retire: insn_count increments on the same edge that leaves the retiring state.
  - If MAX_INSN!=0 and the new count == MAX_INSN, the next state is HALT instead of FETCH.
- insn_count wraps modulo 2^CNT_W when MAX_INSN=0.
- TRAP (1 cycle): trap=1, pc_we=1, pc_sel=11; insn_count unchanged -> FETCH.
- HALT: halted=1, all strobes 0; left only by rst.
- Latency with mem_ready tied high: B=3 cycles, R/I/J/S=4, LW=5.

Test Plan:
- rst for 2 cycles, then release, mem_ready=1 -> ENTRY with pc_we=1, pc_sel=11, then FETCH with ir_we=1; insn_count=0.
- R-type add (opCode=0110011, funct3=000), mem_ready=1 -> FETCH, DECODE, EXEC, WB; op=010; RegWrite=1 only in WB; insn_count 0->1 after 4 cycles.
- LW with mem_ready low for 3 MEM cycles then high -> MemRead high for 4 cycles; WB has Mem2Reg=1, RegWrite=1; total 8 cycles.
- S with mem_ready held low -> after 8 MEM cycles TRAP: trap=1, pc_sel=11, MemWrite=0; insn_count unchanged.
- B with zero=1, then B with zero=0 -> EXEC pc_sel=01, then 00; each retires in 3 cycles. opCode=1111111 -> TRAP after DECODE.
- MAX_INSN=3, stream of I-type addi -> halted=1 after the third WB and stays high; asserting rst mid-HALT returns state=ENTRY and insn_count=0.
